// File: rtl/miniRV_pkg.sv
// miniRV shared definitions: datapath width, ALU opcode encodings and the
// register-index match helper used by forwarding and hazard detection.
package miniRV_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   // ALU opcode encodings carried through the pipeline on 5 bits
   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_AND  = 5'd2;
   localparam logic [4:0] ALU_OR   = 5'd3;
   localparam logic [4:0] ALU_XOR  = 5'd4;
   localparam logic [4:0] ALU_SLL  = 5'd5;
   localparam logic [4:0] ALU_SRL  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_SLT  = 5'd8;
   localparam logic [4:0] ALU_SLTU = 5'd9;

   // True when a producer index names the same architectural register as a
   // consumer index; x0 is hard-wired to zero and never matches.
   function automatic logic idx_match(input logic [REG_IDX_W-1:0] prod_rd,
                                      input logic [REG_IDX_W-1:0] cons_rs);
      return (prod_rd != '0) && (prod_rd == cons_rs);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: per-operand forwarding priority mux. EX/MEM beats MEM/WB, which
// beats the register-file value. The hit flags report a raw index match
// against each source even when fwd_en_i is low, so the non-forwarding build
// can reuse them for RAW hazard detection.
module fwd_sel
   import miniRV_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic                 fwd_en_i,
   input  logic [REG_IDX_W-1:0] rs_i,
   input  logic [W-1:0]         rf_data_i,
   input  logic [REG_IDX_W-1:0] exmem_rd_i,
   input  logic                 exmem_wb_en_i,
   input  logic [W-1:0]         exmem_data_i,
   input  logic [REG_IDX_W-1:0] memwb_rd_i,
   input  logic                 memwb_wb_en_i,
   input  logic [W-1:0]         memwb_data_i,
   output logic [W-1:0]         data_o,
   output logic                 exmem_hit_o,
   output logic                 memwb_hit_o
);

   logic w_exmem_hit;
   logic w_memwb_hit;

   assign w_exmem_hit = exmem_wb_en_i & idx_match(exmem_rd_i, rs_i);
   assign w_memwb_hit = memwb_wb_en_i & idx_match(memwb_rd_i, rs_i);

   assign exmem_hit_o = w_exmem_hit;
   assign memwb_hit_o = w_memwb_hit;

   // Priority select: youngest producer (EX/MEM) first, then MEM/WB, else RF
   always_comb begin
      data_o = rf_data_i;
      if (fwd_en_i && w_exmem_hit) begin
         data_o = exmem_data_i;
      end else if (fwd_en_i && w_memwb_hit) begin
         data_o = memwb_data_i;
      end
   end

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with operand forwarding and load-use
// hazard detection.
// Build option: define MINIRV_FWD_EN to enable operand forwarding. Without
// it, operands always come from the register file and any RAW dependency on
// EX, EX/MEM or MEM/WB raises hazard_stall_o and inserts a bubble.
//
// Pipeline semantics: ex_valid_o marks the EX slot as holding a live
// instruction. Each rising edge applies, highest first: flush_i (kill the
// slot), stall_i (hold the slot, refreshing held operands from forward
// sources), hazard (insert a bubble while decode holds), else capture decode.
module id_ex_reg
   import miniRV_pkg::*;
#(
   parameter int XLEN = miniRV_pkg::XLEN
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            id_valid_i,
   input  logic [XLEN-1:0] id_pc_i,
   input  logic [XLEN-1:0] id_rs1_data_i,
   input  logic [XLEN-1:0] id_rs2_data_i,
   input  logic [XLEN-1:0] id_imm_i,
   input  logic [4:0]      id_rs1_i,
   input  logic [4:0]      id_rs2_i,
   input  logic [4:0]      id_rd_i,
   input  logic [4:0]      id_alu_op_i,
   input  logic            id_b_imm_i,
   input  logic            id_wb_en_i,
   input  logic            id_mem_rd_i,
   input  logic            id_mem_wr_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic [4:0]      exmem_rd_i,
   input  logic            exmem_wb_en_i,
   input  logic [XLEN-1:0] exmem_data_i,
   input  logic [4:0]      memwb_rd_i,
   input  logic            memwb_wb_en_i,
   input  logic [XLEN-1:0] memwb_data_i,
   output logic            ex_valid_o,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [XLEN-1:0] ex_alu_a_o,
   output logic [XLEN-1:0] ex_alu_b_o,
   output logic [XLEN-1:0] ex_rs2_data_o,
   output logic [4:0]      ex_alu_op_o,
   output logic [4:0]      ex_rd_o,
   output logic            ex_wb_en_o,
   output logic            ex_mem_rd_o,
   output logic            ex_mem_wr_o,
   output logic            hazard_stall_o
);

`ifdef MINIRV_FWD_EN
   localparam logic FWD_EN = 1'b1;
`else
   localparam logic FWD_EN = 1'b0;
`endif

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_alu_a;
   logic [XLEN-1:0] r_alu_b;
   logic [XLEN-1:0] r_rs2_data;
   logic [4:0]      r_alu_op;
   logic [4:0]      r_rd;
   logic            r_wb_en;
   logic            r_mem_rd;
   logic            r_mem_wr;
   // Source indices and B-select of the held instruction, needed to refresh
   // its operands from forward sources while the slot is stalled.
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic            r_b_imm;

   logic [4:0]      w_rs1_idx;
   logic [4:0]      w_rs2_idx;
   logic [XLEN-1:0] w_rs1_fwd;
   logic [XLEN-1:0] w_rs2_fwd;
   logic            w_rs1_exmem_hit;
   logic            w_rs1_memwb_hit;
   logic            w_rs2_exmem_hit;
   logic            w_rs2_memwb_hit;
   logic            w_rs1_hit;
   logic            w_rs2_hit;
   logic            w_load_use;
   logic            w_hazard;

   // While stalled the forward muxes look at the held instruction's sources;
   // otherwise at the instruction being decoded.
   assign w_rs1_idx = (FWD_EN && stall_i) ? r_rs1 : id_rs1_i;
   assign w_rs2_idx = (FWD_EN && stall_i) ? r_rs2 : id_rs2_i;

   fwd_sel #(.W(XLEN)) u_fwd_rs1 (
      .fwd_en_i      (FWD_EN),
      .rs_i          (w_rs1_idx),
      .rf_data_i     (id_rs1_data_i),
      .exmem_rd_i    (exmem_rd_i),
      .exmem_wb_en_i (exmem_wb_en_i),
      .exmem_data_i  (exmem_data_i),
      .memwb_rd_i    (memwb_rd_i),
      .memwb_wb_en_i (memwb_wb_en_i),
      .memwb_data_i  (memwb_data_i),
      .data_o        (w_rs1_fwd),
      .exmem_hit_o   (w_rs1_exmem_hit),
      .memwb_hit_o   (w_rs1_memwb_hit)
   );

   fwd_sel #(.W(XLEN)) u_fwd_rs2 (
      .fwd_en_i      (FWD_EN),
      .rs_i          (w_rs2_idx),
      .rf_data_i     (id_rs2_data_i),
      .exmem_rd_i    (exmem_rd_i),
      .exmem_wb_en_i (exmem_wb_en_i),
      .exmem_data_i  (exmem_data_i),
      .memwb_rd_i    (memwb_rd_i),
      .memwb_wb_en_i (memwb_wb_en_i),
      .memwb_data_i  (memwb_data_i),
      .data_o        (w_rs2_fwd),
      .exmem_hit_o   (w_rs2_exmem_hit),
      .memwb_hit_o   (w_rs2_memwb_hit)
   );

   assign w_rs1_hit = w_rs1_exmem_hit | w_rs1_memwb_hit;
   assign w_rs2_hit = w_rs2_exmem_hit | w_rs2_memwb_hit;

   // A load in EX cannot forward its data in time for a dependent in ID.
   assign w_load_use = r_valid & r_mem_rd & (r_rd != 5'd0) & id_valid_i &
                       ((r_rd == id_rs1_i) | (r_rd == id_rs2_i));

`ifdef MINIRV_FWD_EN
   assign w_hazard = w_load_use;
`else
   // Without forwarding every in-flight producer of a source must drain first.
   logic w_ex_raw;
   assign w_ex_raw = r_valid & r_wb_en &
                     (idx_match(r_rd, id_rs1_i) | idx_match(r_rd, id_rs2_i));
   assign w_hazard = w_load_use |
                     (id_valid_i & (w_ex_raw | w_rs1_hit | w_rs2_hit));
`endif

   assign hazard_stall_o = w_hazard;

   // Pipeline slot update: reset, then flush > stall > bubble > capture
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_rs2_data <= '0;
         r_alu_op   <= '0;
         r_rd       <= '0;
         r_wb_en    <= 1'b0;
         r_mem_rd   <= 1'b0;
         r_mem_wr   <= 1'b0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_b_imm    <= 1'b0;
      end else if (flush_i) begin
         r_valid  <= 1'b0;
         r_wb_en  <= 1'b0;
         r_mem_rd <= 1'b0;
         r_mem_wr <= 1'b0;
      end else if (stall_i) begin
         if (FWD_EN && w_rs1_hit) begin
            r_alu_a <= w_rs1_fwd;
         end
         if (FWD_EN && w_rs2_hit) begin
            r_rs2_data <= w_rs2_fwd;
            if (!r_b_imm) begin
               r_alu_b <= w_rs2_fwd;
            end
         end
      end else if (w_hazard) begin
         r_valid  <= 1'b0;
         r_wb_en  <= 1'b0;
         r_mem_rd <= 1'b0;
         r_mem_wr <= 1'b0;
      end else begin
         r_valid    <= id_valid_i;
         r_pc       <= id_pc_i;
         r_alu_a    <= w_rs1_fwd;
         r_alu_b    <= id_b_imm_i ? id_imm_i : w_rs2_fwd;
         r_rs2_data <= w_rs2_fwd;
         r_alu_op   <= id_alu_op_i;
         r_rd       <= id_rd_i;
         r_wb_en    <= id_valid_i & id_wb_en_i;
         r_mem_rd   <= id_valid_i & id_mem_rd_i;
         r_mem_wr   <= id_valid_i & id_mem_wr_i;
         r_rs1      <= id_rs1_i;
         r_rs2      <= id_rs2_i;
         r_b_imm    <= id_b_imm_i;
      end
   end

   assign ex_valid_o    = r_valid;
   assign ex_pc_o       = r_pc;
   assign ex_alu_a_o    = r_alu_a;
   assign ex_alu_b_o    = r_alu_b;
   assign ex_rs2_data_o = r_rs2_data;
   assign ex_alu_op_o   = r_alu_op;
   assign ex_rd_o       = r_rd;
   assign ex_wb_en_o    = r_wb_en;
   assign ex_mem_rd_o   = r_mem_rd;
   assign ex_mem_wr_o   = r_mem_wr;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed checks of capture, forwarding, hazards, stall,
// flush and reset, followed by a randomized run against a reference model.
// Honours MINIRV_FWD_EN the same way as the design.
module tb_id_ex_reg;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst;
   logic            id_valid;
   logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]      id_rs1, id_rs2, id_rd, id_alu_op;
   logic            id_b_imm, id_wb_en, id_mem_rd, id_mem_wr;
   logic            stall, flush;
   logic [4:0]      exmem_rd, memwb_rd;
   logic            exmem_wb_en, memwb_wb_en;
   logic [XLEN-1:0] exmem_data, memwb_data;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc, ex_alu_a, ex_alu_b, ex_rs2_data;
   logic [4:0]      ex_alu_op, ex_rd;
   logic            ex_wb_en, ex_mem_rd, ex_mem_wr, hazard_stall;

   int n_cmp;
   int n_err;

`ifdef MINIRV_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   id_ex_reg #(.XLEN(XLEN)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .id_valid_i     (id_valid),
      .id_pc_i        (id_pc),
      .id_rs1_data_i  (id_rs1_data),
      .id_rs2_data_i  (id_rs2_data),
      .id_imm_i       (id_imm),
      .id_rs1_i       (id_rs1),
      .id_rs2_i       (id_rs2),
      .id_rd_i        (id_rd),
      .id_alu_op_i    (id_alu_op),
      .id_b_imm_i     (id_b_imm),
      .id_wb_en_i     (id_wb_en),
      .id_mem_rd_i    (id_mem_rd),
      .id_mem_wr_i    (id_mem_wr),
      .stall_i        (stall),
      .flush_i        (flush),
      .exmem_rd_i     (exmem_rd),
      .exmem_wb_en_i  (exmem_wb_en),
      .exmem_data_i   (exmem_data),
      .memwb_rd_i     (memwb_rd),
      .memwb_wb_en_i  (memwb_wb_en),
      .memwb_data_i   (memwb_data),
      .ex_valid_o     (ex_valid),
      .ex_pc_o        (ex_pc),
      .ex_alu_a_o     (ex_alu_a),
      .ex_alu_b_o     (ex_alu_b),
      .ex_rs2_data_o  (ex_rs2_data),
      .ex_alu_op_o    (ex_alu_op),
      .ex_rd_o        (ex_rd),
      .ex_wb_en_o     (ex_wb_en),
      .ex_mem_rd_o    (ex_mem_rd),
      .ex_mem_wr_o    (ex_mem_wr),
      .hazard_stall_o (hazard_stall)
   );

   // Clock: 10 time-unit period, first rising edge at t=5
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model: the EX slot as the spec describes it
   typedef struct {
      logic            valid;
      logic [XLEN-1:0] pc, a, b, rs2d;
      logic [4:0]      op, rd, rs1, rs2;
      logic            wb, mrd, mwr, bimm;
   } slot_t;

   slot_t m;

   function automatic void model_reset();
      m = '{valid: 1'b0, pc: '0, a: '0, b: '0, rs2d: '0, op: '0, rd: '0,
            rs1: '0, rs2: '0, wb: 1'b0, mrd: 1'b0, mwr: 1'b0, bimm: 1'b0};
   endfunction

   // Value an operand reads given current forward sources
   function automatic logic [XLEN-1:0] fwd_val(input logic [4:0] rs,
                                               input logic [XLEN-1:0] rf);
      if (FWD && rs != 0 && exmem_wb_en && exmem_rd == rs) return exmem_data;
      if (FWD && rs != 0 && memwb_wb_en && memwb_rd == rs) return memwb_data;
      return rf;
   endfunction

   function automatic logic src_active(input logic [4:0] rs);
      return rs != 0 && ((exmem_wb_en && exmem_rd == rs) ||
                         (memwb_wb_en && memwb_rd == rs));
   endfunction

   // Does decode have to hold this cycle?
   function automatic logic exp_hazard();
      logic [4:0] prod_rd [3];
      logic       prod_en [3];
      logic       hz;
      if (!id_valid) return 1'b0;
      hz = m.valid && m.mrd && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
      if (!FWD) begin
         prod_rd = '{m.rd, exmem_rd, memwb_rd};
         prod_en = '{m.valid && m.wb, exmem_wb_en, memwb_wb_en};
         for (int k = 0; k < 3; k++) begin
            if (prod_en[k] && prod_rd[k] != 0 &&
                (prod_rd[k] == id_rs1 || prod_rd[k] == id_rs2)) hz = 1'b1;
         end
      end
      return hz;
   endfunction

   function automatic slot_t model_next();
      slot_t n;
      n = m;
      if (flush) begin
         n.valid = 0; n.wb = 0; n.mrd = 0; n.mwr = 0;
      end else if (stall) begin
         if (FWD && src_active(m.rs1)) n.a = fwd_val(m.rs1, m.a);
         if (FWD && src_active(m.rs2)) begin
            n.rs2d = fwd_val(m.rs2, m.rs2d);
            if (!m.bimm) n.b = n.rs2d;
         end
      end else if (exp_hazard()) begin
         n.valid = 0; n.wb = 0; n.mrd = 0; n.mwr = 0;
      end else begin
         n.valid = id_valid;
         n.pc    = id_pc;
         n.a     = fwd_val(id_rs1, id_rs1_data);
         n.rs2d  = fwd_val(id_rs2, id_rs2_data);
         n.b     = id_b_imm ? id_imm : n.rs2d;
         n.op    = id_alu_op;
         n.rd    = id_rd;
         n.rs1   = id_rs1;
         n.rs2   = id_rs2;
         n.bimm  = id_b_imm;
         n.wb    = id_valid && id_wb_en;
         n.mrd   = id_valid && id_mem_rd;
         n.mwr   = id_valid && id_mem_wr;
      end
      return n;
   endfunction

   // ---------------- checking and driver tasks
   task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                      input logic [XLEN-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".valid"}, ex_valid, 0);
      chk({tag, ".pc"}, ex_pc, 0);
      chk({tag, ".alu_a"}, ex_alu_a, 0);
      chk({tag, ".alu_b"}, ex_alu_b, 0);
      chk({tag, ".rs2_data"}, ex_rs2_data, 0);
      chk({tag, ".alu_op"}, ex_alu_op, 0);
      chk({tag, ".rd"}, ex_rd, 0);
      chk({tag, ".wb_en"}, ex_wb_en, 0);
      chk({tag, ".mem_rd"}, ex_mem_rd, 0);
      chk({tag, ".mem_wr"}, ex_mem_wr, 0);
      chk({tag, ".hazard"}, hazard_stall, 0);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".hazard"}, hazard_stall, exp_hazard());
      chk({tag, ".valid"}, ex_valid, m.valid);
      chk({tag, ".wb_en"}, ex_wb_en, m.wb);
      chk({tag, ".mem_rd"}, ex_mem_rd, m.mrd);
      chk({tag, ".mem_wr"}, ex_mem_wr, m.mwr);
      if (m.valid) begin
         chk({tag, ".pc"}, ex_pc, m.pc);
         chk({tag, ".alu_a"}, ex_alu_a, m.a);
         chk({tag, ".alu_b"}, ex_alu_b, m.b);
         chk({tag, ".rs2_data"}, ex_rs2_data, m.rs2d);
         chk({tag, ".alu_op"}, ex_alu_op, m.op);
         chk({tag, ".rd"}, ex_rd, m.rd);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fwd();
      exmem_rd = 0; exmem_wb_en = 0; exmem_data = 0;
      memwb_rd = 0; memwb_wb_en = 0; memwb_data = 0;
   endtask

   task automatic set_instr(input logic v, input logic [31:0] pc,
                            input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [4:0] rs2, input logic [31:0] d2,
                            input logic [31:0] imm, input logic bimm,
                            input logic [4:0] rd, input logic [4:0] op,
                            input logic wb, input logic mrd, input logic mwr);
      id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1;
      id_rs2 = rs2; id_rs2_data = d2; id_imm = imm; id_b_imm = bimm;
      id_rd = rd; id_alu_op = op; id_wb_en = wb; id_mem_rd = mrd;
      id_mem_wr = mwr;
   endtask

   // ---------------- stimulus
   initial begin
      slot_t nxt;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      stall = 0; flush = 0;
      clear_fwd();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset state, before any clock edge and after release
      #3;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_all_zero("post_reset");

      // Plain capture: ADD with rs1=5, rs2=7
      set_instr(1, 32'h100, 1, 32'h5, 2, 32'h7, 0, 0, 10, 5'd0, 1, 0, 0);
      #1 chk("cap.hazard", hazard_stall, 0);
      tick();
      chk("cap.valid", ex_valid, 1);
      chk("cap.alu_a", ex_alu_a, 32'h5);
      chk("cap.alu_b", ex_alu_b, 32'h7);
      chk("cap.rs2_data", ex_rs2_data, 32'h7);
      chk("cap.pc", ex_pc, 32'h100);
      chk("cap.rd", ex_rd, 10);
      chk("cap.wb_en", ex_wb_en, 1);

      // Immediate on ALU B, SUB opcode; rs2 data still passed through
      set_instr(1, 32'h104, 1, 32'h9, 2, 32'h4, 32'h55, 1, 11, 5'd1, 1, 0, 0);
      tick();
      chk("imm.alu_b", ex_alu_b, 32'h55);
      chk("imm.rs2_data", ex_rs2_data, 32'h4);
      chk("imm.alu_op", ex_alu_op, 5'd1);

      // Invalid decode captures as a bubble
      set_instr(0, 32'h108, 1, 32'h9, 2, 32'h4, 0, 0, 12, 5'd0, 1, 1, 1);
      tick();
      chk("idle.valid", ex_valid, 0);
      chk("idle.wb_en", ex_wb_en, 0);
      chk("idle.mem_rd", ex_mem_rd, 0);
      chk("idle.mem_wr", ex_mem_wr, 0);

`ifdef MINIRV_FWD_EN
      // EX/MEM wins over MEM/WB for the same index
      set_instr(1, 32'h10c, 3, 32'h11, 4, 32'h44, 0, 0, 12, 5'd0, 1, 0, 0);
      exmem_rd = 3; exmem_wb_en = 1; exmem_data = 32'hAA;
      memwb_rd = 3; memwb_wb_en = 1; memwb_data = 32'hBB;
      #1 chk("fwd_prio.hazard", hazard_stall, 0);
      tick();
      chk("fwd_prio.alu_a", ex_alu_a, 32'hAA);
      chk("fwd_prio.rs2_data", ex_rs2_data, 32'h44);
      // x0 never forwarded; MEM/WB alone feeds rs2
      set_instr(1, 32'h110, 0, 32'h22, 4, 32'h44, 0, 0, 13, 5'd0, 1, 0, 0);
      exmem_rd = 0; exmem_data = 32'hCC;
      memwb_rd = 4; memwb_data = 32'hBB;
      tick();
      chk("fwd_x0.alu_a", ex_alu_a, 32'h22);
      chk("fwd_memwb.rs2_data", ex_rs2_data, 32'hBB);
      chk("fwd_memwb.alu_b", ex_alu_b, 32'hBB);
      // Load-use: lw x5 in EX, add x6,x5,x1 in ID
      clear_fwd();
      set_instr(1, 32'h114, 1, 32'h1, 2, 32'h2, 0, 0, 5, 5'd0, 1, 1, 0);
      tick();
      set_instr(1, 32'h118, 5, 32'h999, 1, 32'h3, 0, 0, 6, 5'd0, 1, 0, 0);
      #1 chk("lu.hazard_on", hazard_stall, 1);
      tick();
      chk("lu.bubble_valid", ex_valid, 0);
      chk("lu.bubble_mem_rd", ex_mem_rd, 0);
      chk("lu.hazard_off", hazard_stall, 0);
      memwb_rd = 5; memwb_wb_en = 1; memwb_data = 32'h42;
      tick();
      chk("lu.valid", ex_valid, 1);
      chk("lu.alu_a", ex_alu_a, 32'h42);
      chk("lu.alu_b", ex_alu_b, 32'h3);
      chk("lu.rd", ex_rd, 6);
`else
      // No forwarding: MEM/WB-only RAW must hold decode and bubble
      set_instr(1, 32'h10c, 3, 32'h11, 4, 32'h44, 0, 0, 12, 5'd0, 1, 0, 0);
      memwb_rd = 3; memwb_wb_en = 1; memwb_data = 32'hBB;
      #1 chk("raw_memwb.hazard", hazard_stall, 1);
      tick();
      chk("raw_memwb.valid", ex_valid, 0);
      chk("raw_memwb.wb_en", ex_wb_en, 0);
      clear_fwd();
      exmem_rd = 4; exmem_wb_en = 1; exmem_data = 32'hAA;
      #1 chk("raw_exmem.hazard", hazard_stall, 1);
      // x0 is never a dependency; operands come from the register file
      set_instr(1, 32'h110, 0, 32'h22, 0, 32'h33, 0, 0, 12, 5'd0, 1, 0, 0);
      exmem_rd = 0;
      #1 chk("raw_x0.hazard", hazard_stall, 0);
      tick();
      chk("raw_x0.valid", ex_valid, 1);
      chk("raw_x0.alu_a", ex_alu_a, 32'h22);
      // Non-load producer in EX also blocks without forwarding
      clear_fwd();
      set_instr(1, 32'h114, 1, 32'h1, 12, 32'h2, 0, 0, 13, 5'd0, 1, 0, 0);
      #1 chk("raw_ex.hazard", hazard_stall, 1);
      tick();
      chk("raw_ex.valid", ex_valid, 0);
`endif

      // Stall 3 cycles while MEM/WB writes the held rs2 index
      clear_fwd();
      set_instr(1, 32'h200, 1, 32'h10, 2, 32'h20, 32'h77, 1, 8, 5'd4, 1, 0, 0);
      #1 chk("stall.hazard", hazard_stall, 0);
      tick();
      stall = 1;
      memwb_rd = 2; memwb_wb_en = 1; memwb_data = 32'h1234;
      set_instr(0, 32'h300, 2, 32'h55, 2, 32'h66, 0, 0, 9, 5'd3, 0, 0, 0);
      repeat (3) tick();
      chk("stall.rs2_data", ex_rs2_data, FWD ? 32'h1234 : 32'h20);
      chk("stall.alu_a", ex_alu_a, 32'h10);
      chk("stall.alu_b", ex_alu_b, 32'h77);
      chk("stall.pc", ex_pc, 32'h200);
      chk("stall.rd", ex_rd, 8);
      chk("stall.alu_op", ex_alu_op, 5'd4);
      chk("stall.valid", ex_valid, 1);

      // Flush with stall still kills the slot
      flush = 1;
      set_instr(1, 32'h304, 1, 32'h1, 3, 32'h2, 0, 0, 9, 5'd0, 1, 0, 0);
      tick();
      chk("flush_stall.valid", ex_valid, 0);
      chk("flush_stall.wb_en", ex_wb_en, 0);
      stall = 0; flush = 0;
      clear_fwd();

      // Flush alone kills a store
      set_instr(1, 32'h400, 1, 32'h1, 3, 32'h2, 0, 0, 0, 5'd0, 0, 0, 1);
      tick();
      chk("store.mem_wr", ex_mem_wr, 1);
      flush = 1;
      tick();
      chk("flush.valid", ex_valid, 0);
      chk("flush.mem_wr", ex_mem_wr, 0);
      flush = 0;

      // Reset pulse inside a cycle while a load-use hazard is active
      set_instr(1, 32'h500, 1, 32'h1, 3, 32'h2, 0, 0, 5, 5'd0, 1, 1, 0);
      tick();
      set_instr(1, 32'h504, 5, 32'h31, 1, 32'h32, 0, 0, 7, 5'd0, 1, 0, 0);
      #1 chk("rst_mid.hazard_before", hazard_stall, 1);
      #1 rst = 1'b1;
      #1 chk_all_zero("rst_mid");
      rst = 1'b0;
      tick();
      chk("rst_release.valid", ex_valid, 1);
      chk("rst_release.alu_a", ex_alu_a, 32'h31);

      // Randomized run against the reference model
      rst = 1'b1;
      #1 rst = 1'b0;
      model_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         set_instr($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 3),
                   $urandom, $urandom_range(0, 3), $urandom, $urandom,
                   $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 9), $urandom_range(0, 1),
                   $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2);
         stall       = $urandom_range(0, 99) < 15;
         flush       = $urandom_range(0, 99) < 8;
         exmem_rd    = $urandom_range(0, 3);
         exmem_wb_en = $urandom_range(0, 1);
         exmem_data  = $urandom;
         memwb_rd    = $urandom_range(0, 3);
         memwb_wb_en = $urandom_range(0, 1);
         memwb_data  = $urandom;
         @(negedge clk);
         chk_model("rand");
         nxt = model_next();
         @(posedge clk);
         m = nxt;
         #1;
      end
      @(negedge clk);
      chk_model("rand_final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 clk_i  in  1  single clock, rising edge.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 id_valid_i  in  1  decode stage holds a valid instruction.
REQ-005 id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i  in  XLEN each  decode PC, register-file reads, immediate.
REQ-006 id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices.
REQ-007 id_alu_op_i  in  5  ALU opcode; id_b_imm_i  in  1  ALU B selects immediate.
REQ-008 id_wb_en_i, id_mem_rd_i, id_mem_wr_i  in  1 each  writeback, load, store.
REQ-009 stall_i  in  1  downstream stall, hold; flush_i  in  1  kill, e.g. branch redirect.
REQ-010 exmem_rd_i  in  5, exmem_wb_en_i  in  1, exmem_data_i  in  XLEN  EX/MEM forward source.
REQ-011 memwb_rd_i  in  5, memwb_wb_en_i  in  1, memwb_data_i  in  XLEN  MEM/WB forward source.
REQ-012 ex_valid_o  out  1; ex_pc_o, ex_alu_a_o, ex_alu_b_o, ex_rs2_data_o  out  XLEN; ex_alu_op_o  out  5; ex_rd_o  out  5; ex_wb_en_o, ex_mem_rd_o, ex_mem_wr_o  out  1.
REQ-013 hazard_stall_o  out  1  combinational; decode/fetch SHALL hold.

Function
REQ-014 All ex_* outputs SHALL be registered; capture latency is one cycle.
REQ-015 Per-edge priority SHALL be: flush_i > stall_i > hazard bubble > capture.
REQ-016 flush_i: ex_valid_o, ex_wb_en_o, ex_mem_rd_o, ex_mem_wr_o SHALL clear next edge; flush with stall_i still clears.
REQ-017 stall_i without flush: all fields hold, except held operands refreshed per REQ-021.
REQ-018 Load-use hazard = ex_valid_o & ex_mem_rd_o & ex_rd_o!=0 & id_valid_i & (ex_rd_o==id_rs1_i | ex_rd_o==id_rs2_i).
REQ-019 On hazard without stall_i/flush_i: hazard_stall_o=1, bubble inserted (ex_valid_o and control bits 0 next edge); hazard clears the following cycle.
REQ-020 Capture: ex_alu_a_o = forwarded rs1; ex_alu_b_o = id_imm_i if id_b_imm_i else forwarded rs2; ex_rs2_data_o = forwarded rs2 always.
REQ-021 While held, a held operand whose source index matches an active forward source SHALL be reloaded with that source's data.
REQ-022 Forward select per operand: EX/MEM if exmem_wb_en_i & exmem_rd_i==rs & rs!=0; else MEM/WB under same rule; else register-file data.
REQ-023 Both sources matching: EX/MEM wins; index 0 never forwarded.
REQ-024 id_valid_i=0 on capture: ex_valid_o and control bits 0; data fields don't-care.

Reset
REQ-025 rst_i SHALL clear every ex_* output to 0 immediately, independent of clk_i.
REQ-026 Reset mid-stall or mid-hazard SHALL leave hazard_stall_o=0 once ex_valid_o is 0.
REQ-027 Deassertion: first capture on the first rising edge with rst_i low.

Configuration
REQ-028 Macro MINIRV_FWD_EN defined: forwarding per REQ-021..023.
REQ-029 Undefined: no forwarding; operands from register file only; hazard_stall_o also asserts for any RAW match (rd!=0, wb_en) against EX, EX/MEM or MEM/WB; bubble rules per REQ-019.

Structure
REQ-030 Shared package miniRV_pkg SHALL hold ALU opcode constants (ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9) and XLEN.
REQ-031 One sub-module fwd_sel (per-operand priority mux), instantiated twice.

Verification
REQ-032 Capture: ADD, rs1=0x5, rs2=0x7, no hazards -> next cycle ex_alu_a_o=0x5, ex_alu_b_o=0x7, ex_valid_o=1.
REQ-033 Forward priority: rs1=x3, exmem x3=0xAA, memwb x3=0xBB -> ex_alu_a_o=0xAA; rs1=x0 with exmem rd=0 -> register-file value.
REQ-034 Load-use: EX holds lw x5; ID add x6,x5,x1 -> hazard_stall_o=1 one cycle, bubble, then add captured with memwb x5 forwarded.
REQ-035 Flush and stall together with valid ID -> ex_valid_o=0 next edge.
REQ-036 Stall 3 cycles while memwb writes rs2 index with 0x1234 -> ex_rs2_data_o=0x1234, other fields unchanged.
REQ-037 rst_i pulse mid-clock-cycle -> all outputs 0 before next edge; without MINIRV_FWD_EN, memwb-only RAW -> hazard_stall_o=1.
